// File: rtl/matmul_loop_ctrl.sv
// Loop-nest sequencer for the matrix-multiply datapath: walks i/j/k (k innermost) and emits one
// registered index/address beat per cycle, with addresses built incrementally from adders only.
module matmul_loop_ctrl #(
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   dim_m,
  input  logic [AW-1:0]   dim_n,
  input  logic [AW-1:0]   dim_k,
  input  logic            stall,
  output logic            busy,
  output logic            valid,
  output logic [AW-1:0]   idx_i,
  output logic [AW-1:0]   idx_j,
  output logic [AW-1:0]   idx_k,
  output logic [2*AW-1:0] a_addr,
  output logic [2*AW-1:0] b_addr,
  output logic [2*AW-1:0] c_addr,
  output logic            acc_clr,
  output logic            acc_wr,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [AW-1:0]   ONE_N = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [2*AW-1:0] ONE_W = {{(2*AW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [AW-1:0]   dm_q, dm_d, dn_q, dn_d, dk_q, dk_d;
  logic [AW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [2*AW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2*AW-1:0] arow_q, arow_d;
  logic            busy_q, busy_d, valid_q, valid_d, done_q, done_d;
  logic            clr_q, clr_d, wr_q, wr_d;

  logic [2*AW-1:0] dn_w, dk_w;
  logic            k_last, j_last, i_last;

  assign dn_w   = {{AW{1'b0}}, dn_q};
  assign dk_w   = {{AW{1'b0}}, dk_q};
  assign k_last = (k_q == dk_q - ONE_N);
  assign j_last = (j_q == dn_q - ONE_N);
  assign i_last = (i_q == dm_q - ONE_N);

  always_comb begin
    state_d = state_q;
    dm_d    = dm_q;
    dn_d    = dn_q;
    dk_d    = dk_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    arow_d  = arow_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    clr_d   = clr_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        clr_d   = 1'b0;
        wr_d    = 1'b0;
        if (start) begin
          dm_d    = dim_m;
          dn_d    = dim_n;
          dk_d    = dim_k;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        i_d    = '0;
        j_d    = '0;
        k_d    = '0;
        a_d    = '0;
        b_d    = '0;
        c_d    = '0;
        arow_d = '0;
        if (dm_q == '0 || dn_q == '0 || dk_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          valid_d = 1'b1;
          clr_d   = 1'b1;
          wr_d    = (dk_q == ONE_N);
        end
      end
      S_RUN: begin
        // A stalled beat keeps every register, so the consumer re-samples an identical beat.
        if (!stall) begin
          if (k_last && j_last && i_last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            clr_d   = 1'b0;
            wr_d    = 1'b0;
          end else if (!k_last) begin
            k_d   = k_q + ONE_N;
            a_d   = a_q + ONE_W;
            b_d   = b_q + dn_w;
            clr_d = 1'b0;
            wr_d  = (k_q + ONE_N == dk_q - ONE_N);
          end else begin
            k_d   = '0;
            c_d   = c_q + ONE_W;
            clr_d = 1'b1;
            wr_d  = (dk_q == ONE_N);
            if (!j_last) begin
              j_d = j_q + ONE_N;
              a_d = arow_q;
              b_d = {{AW{1'b0}}, j_q + ONE_N};
            end else begin
              j_d    = '0;
              i_d    = i_q + ONE_N;
              arow_d = arow_q + dk_w;
              a_d    = arow_q + dk_w;
              b_d    = '0;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        clr_d   = 1'b0;
        wr_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dm_q    <= '0;
      dn_q    <= '0;
      dk_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      arow_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dm_q    <= dm_d;
      dn_q    <= dn_d;
      dk_q    <= dk_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      arow_q  <= arow_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      wr_q    <= wr_d;
    end
  end

  assign busy    = busy_q;
  assign valid   = valid_q;
  assign done    = done_q;
  assign idx_i   = i_q;
  assign idx_j   = j_q;
  assign idx_k   = k_q;
  assign a_addr  = a_q;
  assign b_addr  = b_q;
  assign c_addr  = c_q;
  assign acc_clr = clr_q;
  assign acc_wr  = wr_q;

endmodule

// File: tb/tb_matmul_loop_ctrl.sv
// Scoreboard bench for matmul_loop_ctrl: expected beats are queued from a loop-nest model when a
// product is started and compared against each beat the sequencer emits.
module tb_matmul_loop_ctrl;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst, start, stall;
  logic [AW-1:0]   dim_m, dim_n, dim_k;
  logic            busy, valid, done, acc_clr, acc_wr;
  logic [AW-1:0]   idx_i, idx_j, idx_k;
  logic [2*AW-1:0] a_addr, b_addr, c_addr;

  typedef struct {
    int i, j, k, a, b, c;
    bit clr, wr;
  } beat_t;

  beat_t sb[$];
  int    errs   = 0;
  int    checks = 0;

  matmul_loop_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
    .stall(stall), .busy(busy), .valid(valid), .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .acc_clr(acc_clr), .acc_wr(acc_wr),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_model(input int m, input int n, input int k);
    beat_t bt;
    for (int ii = 0; ii < m; ii++)
      for (int jj = 0; jj < n; jj++)
        for (int kk = 0; kk < k; kk++) begin
          bt.i = ii; bt.j = jj; bt.k = kk;
          bt.a = ii * k + kk;
          bt.b = kk * n + jj;
          bt.c = ii * n + jj;
          bt.clr = (kk == 0);
          bt.wr  = (kk == k - 1);
          sb.push_back(bt);
        end
  endtask

  task automatic scramble_dims();
    dim_m = AW'($urandom_range(1, 255));
    dim_n = AW'($urandom_range(1, 255));
    dim_k = AW'($urandom_range(1, 255));
  endtask

  // start and random dims are held during the whole run to show they are ignored while busy.
  task automatic run_product(input int m, input int n, input int k, input int sb1, input int sb2,
                             input int slen, input int extra, input int abort_beat);
    int    consumed, held, exp_done, limit;
    bit    fin;
    beat_t f;
    push_model(m, n, k);
    exp_done = 2 + m * n * k + extra;
    limit    = exp_done + 10;
    dim_m = AW'(m); dim_n = AW'(n); dim_k = AW'(k);
    start = 1'b1;
    stall = 1'b0;
    consumed = 0; held = 0; fin = 1'b0;
    for (int e = 1; e <= limit && !fin; e++) begin
      @(posedge clk); #1;
      check_eq("busy", busy, 1);
      check_eq("valid", valid, (e >= 2 && sb.size() > 0));
      check_eq("done", done, (e >= 2 && sb.size() == 0));
      if (!valid) check_eq("acc_idle", {acc_clr, acc_wr}, 0);
      if (valid && sb.size() > 0) begin
        f = sb[0];
        check_eq("idx_i", idx_i, f.i);
        check_eq("idx_j", idx_j, f.j);
        check_eq("idx_k", idx_k, f.k);
        check_eq("a_addr", a_addr, f.a);
        check_eq("b_addr", b_addr, f.b);
        check_eq("c_addr", c_addr, f.c);
        check_eq("acc_clr", acc_clr, f.clr);
        check_eq("acc_wr", acc_wr, f.wr);
      end
      if (done) begin
        check_eq("done_cycle", e, exp_done);
        fin   = 1'b1;
        start = 1'b0;
      end else if (valid && abort_beat == consumed + 1) begin
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        #1;
        check_eq("rst_ctl", {busy, valid, done, acc_clr, acc_wr}, 0);
        check_eq("rst_idx", {idx_i, idx_j, idx_k}, 0);
        check_eq("rst_addr", {a_addr, b_addr, c_addr}, 0);
        repeat (3) begin
          @(posedge clk); #1;
          check_eq("rst_done", done, 0);
          check_eq("rst_busy", busy, 0);
        end
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check_eq("post_rst_busy", busy, 0);
        return;
      end else begin
        start = 1'b1;
        scramble_dims();
        if (valid && (consumed + 1 == sb1 || consumed + 1 == sb2) && held < slen) begin
          stall = 1'b1;
          held++;
        end else begin
          stall = 1'b0;
          if (valid && sb.size() > 0) begin
            void'(sb.pop_front());
            consumed++;
            held = 0;
          end
        end
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (!fin) begin
      check_eq("done_timeout", done, 1);
      sb.delete();
    end else begin
      @(posedge clk); #1;
      check_eq("idle_busy", busy, 0);
      check_eq("idle_valid", valid, 0);
      check_eq("idle_done", done, 0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    dim_m = '0; dim_n = '0; dim_k = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctl", {busy, valid, done, acc_clr, acc_wr}, 0);
    check_eq("reset_idx", {idx_i, idx_j, idx_k}, 0);
    check_eq("reset_addr", {a_addr, b_addr, c_addr}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_product(2, 2, 2, 0, 0, 0, 0, 0);
    run_product(2, 3, 4, 0, 0, 0, 0, 0);
    run_product(3, 3, 1, 0, 0, 0, 0, 0);
    run_product(3, 3, 3, 5, 27, 3, 6, 0);
    run_product(2, 0, 2, 0, 0, 0, 0, 0);
    run_product(2, 2, 2, 0, 0, 0, 0, 4);
    run_product(2, 2, 2, 0, 0, 0, 0, 0);
    run_product(1, 1, 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
